// File: rtl/fa_serial_sched.sv
// Bit-serial adder sequencer: round-robin arbitrates two requesters, then steps
// one external full-adder cell LSB-first for WIDTH cycles and returns {carry, sum}.
module fa_serial_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH:0]   res,
    output logic             res_valid,
    output logic             res_id,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa, opb, sumr;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             last_gnt;
    logic             any_req;
    logic             gnt;
    logic             last_bit;

    // On a tie the requester that was not served last time wins.
    assign any_req  = req0 | req1;
    assign gnt      = (req0 & req1) ? ~last_gnt : req1;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_cin   = 1'b0;
        case (state)
            IDLE: if (any_req) state_nx = RUN;
            RUN: begin
                busy   = 1'b1;
                fa_a   = opa[0];
                fa_b   = opb[0];
                fa_cin = carry_q;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa       <= '0;
            opb       <= '0;
            sumr      <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            last_gnt  <= 1'b1;
            res       <= '0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            res_valid <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    opa      <= gnt ? a1 : a0;
                    opb      <= gnt ? b1 : b0;
                    carry_q  <= 1'b0;
                    cnt      <= '0;
                    last_gnt <= gnt;
                    res_id   <= gnt;
                    ack0     <= ~gnt;
                    ack1     <= gnt;
                end
                RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands at the bottom after WIDTH shifts.
                    sumr    <= {fa_sum, sumr[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    opa     <= opa >> 1;
                    opb     <= opb >> 1;
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        res       <= {fa_cout, fa_sum, sumr[WIDTH-1:1]};
                        res_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fa_serial_sched.sv
// Randomized and directed bench for fa_serial_sched against a cycles-since-capture model.
module tb_fa_serial_sched;
    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         ack0, ack1, res_valid, res_id, busy;
    logic [W:0]   res;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    always #5 clk = ~clk;

    fa_serial_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .res(res), .res_valid(res_valid), .res_id(res_id), .busy(busy),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    // The external full-adder cell.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: phase = cycles since capture (0 = idle).
    int phase = 0, last = 1, id_e = 0, res_e = 0, ca = 0, cb = 0;
    int grants[$];
    // Requesters
    bit           h0 = 0, h1 = 0;
    logic [W-1:0] oa0 = '0, ob0 = '0, oa1 = '0, ob1 = '0;
    int           mode = 0;

    task automatic apply();
        req0 = h0; a0 = oa0; b0 = ob0;
        req1 = h1; a1 = oa1; b1 = ob1;
    endtask

    task automatic cycle();
        bit s_rst, s0, s1;
        int k, m, e_ack0, e_ack1, e_a, e_b, e_c, g;
        s_rst = rst; s0 = req0; s1 = req1;
        @(posedge clk);
        if (s_rst) begin
            phase = 0; last = 1; id_e = 0; res_e = 0;
        end else if (phase == 0) begin
            if (s0 || s1) begin
                g = (s0 && s1) ? 1 - last : (s1 ? 1 : 0);
                last = g; id_e = g; grants.push_back(g);
                ca = g ? int'(oa1) : int'(oa0);
                cb = g ? int'(ob1) : int'(ob0);
                phase = 1;
            end
        end else if (phase == W + 1) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == W + 1) res_e = ca + cb;
        end
        @(negedge clk);
        e_ack0 = (phase == 1 && id_e == 0);
        e_ack1 = (phase == 1 && id_e == 1);
        e_a = 0; e_b = 0; e_c = 0;
        if (phase >= 1 && phase <= W) begin
            k = phase - 1;
            m = (1 << k) - 1;
            e_a = (ca >> k) & 1;
            e_b = (cb >> k) & 1;
            e_c = ((ca & m) + (cb & m)) >> k;
        end
        chk("ack0", ack0, e_ack0);
        chk("ack1", ack1, e_ack1);
        chk("busy", busy, phase > 0);
        chk("res_valid", res_valid, phase == W + 1);
        chk("res", res, res_e);
        chk("res_id", res_id, id_e);
        chk("fa_a", fa_a, e_a);
        chk("fa_b", fa_b, e_b);
        chk("fa_cin", fa_cin, e_c);
        if (e_ack0) h0 = 0;
        if (e_ack1) h1 = 0;
        if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) begin
            if (!h0) begin h0 = 1; oa0 = W'($urandom_range(0, MAXV)); ob0 = W'($urandom_range(0, MAXV)); end
        end
        if (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)) begin
            if (!h1) begin h1 = 1; oa1 = W'($urandom_range(0, MAXV)); ob1 = W'($urandom_range(0, MAXV)); end
        end
        apply();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        apply();
        cycle();
        rst = 1'b0;
        run(2);

        // Single request on port 0: 5 + 9
        h0 = 1; oa0 = 4'd5; ob0 = 4'd9; apply();
        run(8);
        // Port 1: 15 + 15, carry chain
        h1 = 1; oa1 = 4'd15; ob1 = 4'd15; apply();
        run(8);

        // Tie from reset: port 0 first, then port 1
        do_reset();
        grants.delete();
        h0 = 1; oa0 = 4'd4; ob0 = 4'd3;
        h1 = 1; oa1 = 4'd7; ob1 = 4'd8; apply();
        run(14);
        chk("tie_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("tie_first", grants[0], 0);
            chk("tie_second", grants[1], 1);
        end

        // Both held continuously: grants must alternate
        grants.delete();
        mode = 2;
        run(4 * (W + 2));
        mode = 0; h0 = 0; h1 = 0; apply();
        run(8);
        chk("alt_count", grants.size(), 4);
        for (int i = 1; i < grants.size(); i++) chk("alt_order", grants[i], 1 - grants[i-1]);

        // Reset during RUN cycle 2, then 0 + 0
        h0 = 1; oa0 = 4'd9; ob0 = 4'd6; apply();
        for (int i = 0; i < 20 && phase != 2; i++) cycle();
        chk("reach_run2", phase, 2);
        h0 = 0; apply();
        do_reset();
        h0 = 1; oa0 = 4'd0; ob0 = 4'd0; apply();
        run(8);

        // req1 raised while port 0 is running
        h0 = 1; oa0 = 4'd11; ob0 = 4'd2; apply();
        run(3);
        h1 = 1; oa1 = 4'd6; ob1 = 4'd13; apply();
        run(14);

        // Random traffic
        mode = 1;
        run(1500);
        mode = 0;
        run(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fa_serial_sched.md
# fa_serial_sched

Bit-serial sequencer and two-port arbiter for the 1-bit full-adder cell. It accepts add requests from two requesters and picks one by round-robin. It then drives a single external full adder LSB-first for WIDTH cycles, carrying between bits in a flop, and returns the WIDTH+1-bit sum on a shared result bus. This lets one full-adder cell replace the WIDTH-cell ripple-carry adder where area matters more than latency.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0  in  1  requester 0 request (level)
- a0, b0  in  WIDTH  requester 0 operands, stable while req0 high until ack0
- req1  in  1  requester 1 request (level)
- a1, b1  in  WIDTH  requester 1 operands, stable while req1 high until ack1
- ack0, ack1  out  1  one-cycle pulse, operands captured
- res  out  WIDTH+1  {carry, sum}, holds the last value
- res_valid  out  1  one-cycle pulse, res valid
- res_id  out  1  requester that owns res
- busy  out  1  high in RUN and DONE
- fa_a, fa_b, fa_cin  out  1  to full-adder cell
- fa_sum, fa_cout  in  1  from full-adder cell (combinational)

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - No request: stay in IDLE.
  - Any request: at the clock edge, grant, capture the granted a/b into shift registers opa/opb, clear carry_q, set cnt=0, and go to RUN.
  - Record the granted id in last_gnt and res_id.
  - Assert the registered ack of the granted requester for the next cycle only.
- Arbitration
  - Single request: that requester wins.
  - Both requests: the requester ≠ last_gnt wins.
  - last_gnt resets to 1, so requester 0 wins the first tie.
- RUN
  - Combinationally: fa_a=opa[0], fa_b=opb[0], fa_cin=carry_q.
  - Each edge: shift fa_sum into the sum register from the MSB side, carry_q←fa_cout, shift opa/opb right, cnt++.
  - After the WIDTH-th bit (cnt=WIDTH-1 at the edge): load res={fa_cout, sum bits}, assert res_valid, go to DONE.
- DONE: one cycle with res_valid=1, then IDLE. No capture happens in DONE.
- Outside RUN, fa_a/fa_b/fa_cin are 0.
- Arithmetic: unsigned. res = a + b exactly, range 0..2^(WIDTH+1)-2, no overflow.
- A requester that still holds req high when IDLE is re-entered is treated as a new request.
- Requests arriving during RUN/DONE wait. They are not lost while held, and receive no ack until captured.

## Timing
- Reset values:
  - Outputs: ack0=ack1=0, res=0, res_valid=0, res_id=0, busy=0, fa_*=0.
  - Internal: state=IDLE, last_gnt=1, cnt=0, carry_q=0.
- Reset mid-operation: the op is abandoned. No res_valid and no further ack. res returns to 0.
- Latency, with capture at edge E0:
  - ack high in cycle 1.
  - RUN occupies cycles 1..WIDTH.
  - res_valid high in cycle WIDTH+1.
  - Back in IDLE in cycle WIDTH+2, where the next capture is possible.
- Throughput: one add per WIDTH+2 cycles.
- ack and res_valid never assert for more than one cycle. At most one ack per capture.
- busy is high from cycle 1 through cycle WIDTH+1 inclusive.

## Test plan
- Port 0, a0=5, b0=9, single request, held until ack0 → ack0 in cycle 1, res=14, res_id=0, res_valid in cycle 5 (WIDTH=4), busy high cycles 1–5.
- Port 1, a1=15, b1=15 → res=30 (carry bit 1), res_id=1. Check fa_cin sequence 0,1,1,1 across the RUN cycles.
- req0 and req1 both asserted from reset and held until each ack:
  - Ops: 4+3 on port 0, 7+8 on port 1.
  - Expected: port 0 served first (res=7, res_id=0), then port 1 (res=15, res_id=1), six cycles apart.
- Both requests held continuously for four ops → grants alternate 0,1,0,1. Each res matches its id's operands.
- Assert rst for one cycle during RUN (cycle 2) → no res_valid, all outputs at reset values the next cycle. A subsequent 0+0 request returns res=0 normally.
- req1 raised during port 0's RUN → no ack1 until IDLE. Captured on the IDLE edge, with ack1 exactly one cycle after that edge.
